ahb_arbiter: RTL

Multi-master AHB bus arbiter that shares the single AHB address/data path, and the slave select logic behind it, among several masters. It samples bus requests and lock requests, registers a one-hot grant, and drives the HMASTER index that steers the master-side address/control and write-data muxes. Grant changes are deferred so that fixed-length bursts and locked sequences are never split. Handover of address-phase ownership is always aligned to HREADY.

---
 rtl/ahb_arbiter_if.sv | 34 +++
 rtl/ahb_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
//   Bundles the arbiter's bus-facing signals.
//   master modport : request side (drives HBUSREQ/HLOCK/HTRANS/HBURST/HREADY,
//                    observes HGRANT/HMASTER/HMASTLOCK)
//   slave modport  : arbiter side (the reverse)
//   HBUSREQ/HLOCK  : per-master request and lock request
//   HTRANS/HBURST  : transfer and burst type of the currently muxed master
//   HREADY         : bus-wide ready
//   HGRANT         : one-hot grant
//   HMASTER        : address-phase owner index
//   HMASTLOCK      : current address phase belongs to a locked sequence
interface ahb_arbiter_if #(
   parameter int NO_OF_MASTERS  = 2,
   parameter int MASTER_ID_BITS = 1
);
   logic [NO_OF_MASTERS-1:0]  HBUSREQ;
   logic [NO_OF_MASTERS-1:0]  HLOCK;
   logic [1:0]                HTRANS;
   logic [2:0]                HBURST;
   logic                      HREADY;
   logic [NO_OF_MASTERS-1:0]  HGRANT;
   logic [MASTER_ID_BITS-1:0] HMASTER;
   logic                      HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Multi-master AHB arbiter. Registers a one-hot grant, defers re-arbitration
//   until a fixed-length burst reaches its last beat and the owner has released
//   HLOCK, and hands address-phase ownership (HMASTER/HMASTLOCK) over on HREADY.
//   Ports:
//     HCLK    : clock, rising edge
//     HRESETn : synchronous active-low reset
//     bus     : ahb_arbiter_if.slave (requests/transfer info in, grant/owner out)
//   Build option:
//     ARB_FIXED_PRIO_EN : lowest-indexed requester wins (no rotating pointer);
//                         undefined -> round-robin.
module ahb_arbiter #(
   parameter int NO_OF_MASTERS  = 2,
   parameter int DEFAULT_MASTER = 0,
   parameter int MASTER_ID_BITS = 1
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   ahb_arbiter_if.slave  bus
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [MASTER_ID_BITS-1:0] DEF_IDX = MASTER_ID_BITS'(DEFAULT_MASTER);
   localparam logic [NO_OF_MASTERS-1:0]  GRANT_RST =
      {{(NO_OF_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

   logic [4:0]                beat_q, beat_d, burst_len;
   logic [NO_OF_MASTERS-1:0]  hgrant_q, hgrant_d;
   logic [MASTER_ID_BITS-1:0] hmaster_q, hmaster_d;
   logic                      hmastlock_q, hmastlock_d;
   logic [MASTER_ID_BITS-1:0] gidx, winner;
   logic                      arb_ok;

   // Index of the currently granted master (grant is always one-hot).
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NO_OF_MASTERS; i++)
         if (hgrant_q[i]) gidx = MASTER_ID_BITS'(i);
   end

   always_comb begin
      case (bus.HBURST)
         3'd2, 3'd3: burst_len = 5'd3;
         3'd4, 3'd5: burst_len = 5'd7;
         3'd6, 3'd7: burst_len = 5'd15;
         default:    burst_len = 5'd0;   // SINGLE / INCR
      endcase
   end

   // Remaining beats of a fixed-length burst; BUSY and wait states hold it.
   always_comb begin
      beat_d = beat_q;
      if (bus.HREADY) begin
         case (bus.HTRANS)
            TR_NONSEQ: beat_d = burst_len;
            TR_SEQ:    beat_d = (beat_q != 5'd0) ? beat_q - 5'd1 : 5'd0;
            TR_IDLE:   beat_d = 5'd0;
            default:   beat_d = beat_q;
         endcase
      end
   end

   // Uses the pre-update counter, so a NONSEQ edge still sees the old count.
   assign arb_ok = (beat_q <= 5'd1) && !bus.HLOCK[gidx];

`ifdef ARB_FIXED_PRIO_EN
   // Descending scan leaves the lowest-indexed requester in winner.
   always_comb begin
      winner = DEF_IDX;
      for (int i = NO_OF_MASTERS - 1; i >= 0; i--)
         if (bus.HBUSREQ[i]) winner = MASTER_ID_BITS'(i);
   end
`else
   logic [MASTER_ID_BITS-1:0] ptr_q, ptr_d;
   logic [MASTER_ID_BITS-1:0] win_hi, win_lo;
   logic                      hi_found, lo_found;

   // Round-robin as two descending scans: lowest requester at/after the
   // pointer, else lowest requester overall (the wrap-around case).
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
         if (bus.HBUSREQ[i]) begin
            win_lo   = MASTER_ID_BITS'(i);
            lo_found = 1'b1;
            if (i >= int'(ptr_q)) begin
               win_hi   = MASTER_ID_BITS'(i);
               hi_found = 1'b1;
            end
         end
      end
      if (hi_found)      winner = win_hi;
      else if (lo_found) winner = win_lo;
      else               winner = DEF_IDX;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (arb_ok)
         ptr_d = (int'(winner) == NO_OF_MASTERS - 1) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) ptr_q <= DEF_IDX;
      else          ptr_q <= ptr_d;
   end
`endif

   always_comb begin
      hgrant_d = hgrant_q;
      if (arb_ok) begin
         hgrant_d         = '0;
         hgrant_d[winner] = 1'b1;
      end
   end

   // Ownership only moves at an HREADY edge.
   always_comb begin
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      if (bus.HREADY) begin
         hmaster_d   = gidx;
         hmastlock_d = bus.HLOCK[gidx];
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         beat_q      <= 5'd0;
         hgrant_q    <= GRANT_RST;
         hmaster_q   <= DEF_IDX;
         hmastlock_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         hgrant_q    <= hgrant_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
      end
   end

   assign bus.HGRANT    = hgrant_q;
   assign bus.HMASTER   = hmaster_q;
   assign bus.HMASTLOCK = hmastlock_q;

endmodule
